irq_prio_ctrl: RTL and testbench

//  Parametrised interrupt controller: per-source level/edge mode, pending latch, enable,
//  N-level priority with threshold, and claim/complete handshake tracking in-service sources.

---
 rtl/irq_prio_ctrl.sv | 161 ++++++++++++++++
 tb/tb_irq_prio_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_prio_ctrl.sv
// Interrupt controller: synchronised level/edge sources, priority arbitration with a
// threshold, and claim/complete tracking of in-service sources behind a register bus.
module irq_prio_ctrl #(
  parameter int unsigned NUM_IRQ = 32,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               rvalid_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_o
);
  localparam int unsigned ID_W = $clog2(NUM_IRQ + 1);
  localparam logic [5:0] W_MODE  = 6'h00;
  localparam logic [5:0] W_EN    = 6'h01;
  localparam logic [5:0] W_PEND  = 6'h02;
  localparam logic [5:0] W_INSV  = 6'h03;
  localparam logic [5:0] W_THR   = 6'h04;
  localparam logic [5:0] W_CLAIM = 6'h05;
  localparam logic [5:0] W_GEN   = 6'h06;
  localparam logic [5:0] W_RAW   = 6'h07;
  localparam logic [ID_W-1:0]    ID_NONE = ID_W'(NUM_IRQ);
  localparam logic [NUM_IRQ-1:0] ONE     = NUM_IRQ'(1'b1);

  logic [NUM_IRQ-1:0] mode_r, enable_r, pending_r, inserv_r;
  logic [NUM_IRQ-1:0] sync1_r, sync2_r, prev_r;
  logic [PRIO_W-1:0]  thresh_r;
  logic               gen_r;
  logic [PRIO_W-1:0]  prio_r [NUM_IRQ];
  logic               irq_r, rvalid_r;
  logic [31:0]        rdata_r;

  logic [5:0]         word_s;
  logic [4:0]         prio_idx_s;
  logic               wr_s, rd_s, claim_s, complete_s, prio_sel_s, cmp_ok_s;
  logic [7:0]         cmp_id_s;
  logic [NUM_IRQ-1:0] prio_nz_s, elig_s, edge_s, mode_chg_s, sw_set_s;
  logic [NUM_IRQ-1:0] claim_mask_s, cmp_mask_s, pending_nxt_s, inserv_nxt_s;
  logic [PRIO_W-1:0]  best_prio_s;
  logic [ID_W-1:0]    best_id_s;
  logic               best_valid_s, irq_nxt_s;
  logic [31:0]        rdata_s;
  logic               unused_s;

  assign unused_s   = ^addr_i[1:0];
  assign word_s     = addr_i[7:2];
  assign prio_idx_s = addr_i[6:2];
  assign prio_sel_s = addr_i[7] && (32'(prio_idx_s) < NUM_IRQ);
  assign wr_s       = req_i & we_i;
  assign rd_s       = req_i & ~we_i;
  assign claim_s    = rd_s && (word_s == W_CLAIM);
  assign complete_s = wr_s && (word_s == W_CLAIM);
  assign cmp_id_s   = wdata_i[7:0];
  assign cmp_ok_s   = complete_s && (32'(cmp_id_s) < NUM_IRQ);

  // Flags sources whose priority is non-zero.
  always_comb begin
    prio_nz_s = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      prio_nz_s[i] = (prio_r[i] != '0);
    end
  end

  assign elig_s = pending_r & enable_r & ~inserv_r & prio_nz_s;

  // Arbitration: strict greater-than keeps the lowest index on equal priority.
  always_comb begin
    logic take;
    take        = 1'b0;
    best_prio_s = '0;
    best_id_s   = ID_NONE;
    for (int i = 0; i < NUM_IRQ; i++) begin
      take        = elig_s[i] && (prio_r[i] > best_prio_s);
      best_prio_s = take ? prio_r[i] : best_prio_s;
      best_id_s   = take ? ID_W'(i) : best_id_s;
    end
  end

  assign best_valid_s = (best_prio_s != '0);
  assign irq_nxt_s    = gen_r & best_valid_s & (best_prio_s > thresh_r);

  // A new edge or a software set wins over the clear caused by a same-cycle claim.
  assign claim_mask_s  = (claim_s && best_valid_s) ? (ONE << best_id_s) : '0;
  assign cmp_mask_s    = cmp_ok_s ? (ONE << cmp_id_s) : '0;
  assign mode_chg_s    = (wr_s && (word_s == W_MODE)) ? (mode_r ^ wdata_i[NUM_IRQ-1:0]) : '0;
  assign sw_set_s      = (wr_s && (word_s == W_PEND)) ? wdata_i[NUM_IRQ-1:0] : '0;
  assign edge_s        = sync2_r & ~prev_r;
  assign pending_nxt_s = ~mode_chg_s &
                         ((mode_r & (edge_s | sw_set_s | (pending_r & ~claim_mask_s))) |
                          (~mode_r & sync2_r));
  assign inserv_nxt_s  = (inserv_r | claim_mask_s) & ~cmp_mask_s;

  // Read data multiplexer; a CLAIM read returns the current winner.
  always_comb begin
    rdata_s = 32'd0;
    case (word_s)
      W_MODE:  rdata_s = 32'(mode_r);
      W_EN:    rdata_s = 32'(enable_r);
      W_PEND:  rdata_s = 32'(pending_r);
      W_INSV:  rdata_s = 32'(inserv_r);
      W_THR:   rdata_s = 32'(thresh_r);
      W_CLAIM: rdata_s = 32'(best_id_s);
      W_GEN:   rdata_s = {31'd0, gen_r};
      W_RAW:   rdata_s = 32'(sync2_r);
      default: rdata_s = prio_sel_s ? 32'(prio_r[prio_idx_s]) : 32'd0;
    endcase
  end

  // Synchronisers, interrupt tracking state, bus registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_r    <= '0;
      enable_r  <= '0;
      pending_r <= '0;
      inserv_r  <= '0;
      sync1_r   <= '0;
      sync2_r   <= '0;
      prev_r    <= '0;
      thresh_r  <= '0;
      gen_r     <= 1'b0;
      irq_r     <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
      for (int i = 0; i < NUM_IRQ; i++) begin
        prio_r[i] <= '0;
      end
    end else begin
      sync1_r   <= irq_i;
      sync2_r   <= sync1_r;
      prev_r    <= sync2_r;
      pending_r <= pending_nxt_s;
      inserv_r  <= inserv_nxt_s;
      irq_r     <= irq_nxt_s;
      rvalid_r  <= req_i;
      rdata_r   <= rd_s ? rdata_s : 32'd0;
      if (wr_s) begin
        case (word_s)
          W_MODE:  mode_r   <= wdata_i[NUM_IRQ-1:0];
          W_EN:    enable_r <= wdata_i[NUM_IRQ-1:0];
          W_THR:   thresh_r <= wdata_i[PRIO_W-1:0];
          W_GEN:   gen_r    <= wdata_i[0];
          default: begin
            if (prio_sel_s) begin
              prio_r[prio_idx_s] <= wdata_i[PRIO_W-1:0];
            end
          end
        endcase
      end
    end
  end

  assign rdata_o  = rdata_r;
  assign rvalid_o = rvalid_r;
  assign irq_o    = irq_r;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Scoreboard bench for irq_prio_ctrl: bus accesses queue their expected read data and a
// monitor compares on every rvalid; irq_o is checked directly at chosen cycles.
module tb_irq_prio_ctrl;
  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        req_i   = 1'b0;
  logic        we_i    = 1'b0;
  logic [7:0]  addr_i  = 8'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic [31:0] irq_i   = 32'd0;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        chk;
    logic [7:0]  addr;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;

  irq_prio_ctrl #(.NUM_IRQ(32), .PRIO_W(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .irq_i(irq_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every rvalid consumes one queued access; reads are compared.
  always @(negedge clk_i) begin
    if (rst_ni && rvalid_o) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_rvalid got=1 want=0");
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) begin
          total++;
          if (rdata_o !== mon_e.exp) begin
            bad++;
            $display("FAIL rd@%h got=%h want=%h", mon_e.addr, rdata_o, mon_e.exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bus(input logic we, input logic [7:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp);
    sb_t e;
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    e.chk = chk; e.addr = a; e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp);
    bus(1'b0, a, 32'd0, 1'b1, exp);
  endtask

  task automatic pulse(input int i);
    @(negedge clk_i);
    irq_i[i] = 1'b1;
    @(posedge clk_i);
    #1;
    irq_i[i] = 1'b0;
  endtask

  task automatic check_irq(input logic exp, input string name);
    total++;
    if (irq_o !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, irq_o, exp);
    end
  endtask

  task automatic check_all_zero();
    rd(8'h00, 32'd0); rd(8'h04, 32'd0); rd(8'h08, 32'd0); rd(8'h0C, 32'd0);
    rd(8'h10, 32'd0); rd(8'h14, 32'd32); rd(8'h18, 32'd0); rd(8'h1C, 32'd0);
    rd(8'h80, 32'd0); rd(8'h8C, 32'd0); rd(8'h9C, 32'd0); rd(8'hFC, 32'd0);
  endtask

  initial begin
    // T1: reset state, unmapped and read-only registers
    cyc(3);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(1);
    check_irq(1'b0, "t1_irq_reset");
    check_all_zero();
    rd(8'h20, 32'd0);
    wr(8'h40, 32'hFFFF_FFFF);
    rd(8'h40, 32'd0);
    wr(8'h0C, 32'h0000_00FF);
    rd(8'h0C, 32'd0);
    wr(8'h18, 32'd1);
    rd(8'h18, 32'd1);

    // T2: level source 5, latency and claim/complete
    wr(8'h94, 32'd3);
    wr(8'h04, 32'h0000_0020);
    @(negedge clk_i);
    irq_i[5] = 1'b1;
    cyc(3);
    check_irq(1'b0, "t2_irq_early");
    cyc(1);
    check_irq(1'b1, "t2_irq_n3");
    rd(8'h14, 32'd5);
    cyc(1);
    check_irq(1'b0, "t2_irq_after_claim");
    wr(8'h14, 32'd5);
    cyc(1);
    check_irq(1'b1, "t2_irq_after_complete");
    irq_i[5] = 1'b0;
    wr(8'h94, 32'd0);
    wr(8'h04, 32'd0);
    cyc(4);

    // T3: priority and tie-break with back-to-back claims
    wr(8'h88, 32'd2);
    wr(8'h9C, 32'd6);
    wr(8'hA4, 32'd6);
    wr(8'h04, 32'h0000_0284);
    irq_i[2] = 1'b1; irq_i[7] = 1'b1; irq_i[9] = 1'b1;
    cyc(4);
    rd(8'h14, 32'd7);
    rd(8'h14, 32'd9);
    rd(8'h14, 32'd2);
    rd(8'h14, 32'd32);
    rd(8'h0C, 32'h0000_0284);
    irq_i[2] = 1'b0; irq_i[7] = 1'b0; irq_i[9] = 1'b0;
    wr(8'h14, 32'd7); wr(8'h14, 32'd9); wr(8'h14, 32'd2);
    cyc(4);
    rd(8'h0C, 32'd0);
    rd(8'h08, 32'd0);
    wr(8'h04, 32'd0);
    wr(8'h88, 32'd0); wr(8'h9C, 32'd0); wr(8'hA4, 32'd0);

    // T4: edge source 3, latching, claim race and software set
    wr(8'h00, 32'h0000_0008);
    wr(8'h04, 32'h0000_0008);
    wr(8'h8C, 32'd1);
    pulse(3);
    cyc(4);
    rd(8'h08, 32'h0000_0008);
    cyc(5);
    rd(8'h08, 32'h0000_0008);
    rd(8'h14, 32'd3);
    rd(8'h08, 32'd0);
    rd(8'h0C, 32'h0000_0008);
    wr(8'h14, 32'd3);
    pulse(3);
    cyc(4);
    rd(8'h08, 32'h0000_0008);
    pulse(3);
    cyc(1);
    rd(8'h14, 32'd3);
    rd(8'h08, 32'h0000_0008);
    wr(8'h14, 32'd3);
    rd(8'h14, 32'd3);
    wr(8'h14, 32'd3);
    rd(8'h08, 32'd0);
    wr(8'h08, 32'h0000_0028);
    rd(8'h08, 32'h0000_0008);
    rd(8'h14, 32'd3);
    wr(8'h14, 32'd3);
    wr(8'h00, 32'd0);
    wr(8'h04, 32'd0);
    wr(8'h8C, 32'd0);
    cyc(2);

    // T5: threshold and complete filtering
    wr(8'h10, 32'd4);
    wr(8'h84, 32'd4);
    wr(8'h04, 32'h0000_0002);
    irq_i[1] = 1'b1;
    cyc(5);
    check_irq(1'b0, "t5_irq_thresh_eq");
    rd(8'h14, 32'd1);
    wr(8'h14, 32'd1);
    wr(8'h10, 32'd3);
    cyc(2);
    check_irq(1'b1, "t5_irq_thresh_below");
    wr(8'h10, 32'hFFFF_FFFF);
    rd(8'h10, 32'd7);
    cyc(2);
    check_irq(1'b0, "t5_irq_thresh_max");
    wr(8'h10, 32'd0);
    wr(8'h84, 32'd0);
    rd(8'h14, 32'd32);
    wr(8'h84, 32'd4);
    rd(8'h14, 32'd1);
    wr(8'h14, 32'd40);
    rd(8'h0C, 32'h0000_0002);
    wr(8'h14, 32'd33);
    rd(8'h0C, 32'h0000_0002);
    wr(8'h14, 32'd6);
    rd(8'h0C, 32'h0000_0002);
    wr(8'h14, 32'd1);
    rd(8'h0C, 32'd0);
    irq_i[1] = 1'b0;
    wr(8'h04, 32'd0);
    wr(8'h84, 32'd0);
    cyc(4);

    // T6: asynchronous reset with work in flight
    wr(8'h00, 32'h0000_0008);
    wr(8'h88, 32'd2);
    wr(8'h9C, 32'd6);
    wr(8'h8C, 32'd1);
    wr(8'h04, 32'h0000_008C);
    irq_i[2] = 1'b1; irq_i[7] = 1'b1;
    cyc(4);
    rd(8'h14, 32'd7);
    rd(8'h14, 32'd2);
    irq_i[2] = 1'b0; irq_i[7] = 1'b0;
    pulse(3);
    cyc(4);
    rd(8'h0C, 32'h0000_0084);
    rd(8'h08, 32'h0000_0008);
    cyc(2);
    check_irq(1'b1, "t6_irq_before_reset");
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_irq(1'b0, "t6_irq_async_drop");
    cyc(2);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(1);
    check_irq(1'b0, "t6_irq_after_reset");
    check_all_zero();

    cyc(3);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL missing_rvalid got=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
